// File: rtl/regfile_scoreboard_pkg.sv
// rtl/regfile_scoreboard_pkg.sv - shared defaults and constants for the register file scoreboard
package regfile_scoreboard_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;
  // Architectural zero register: reads 0, ignores writes, never busy
  localparam int ZERO_REG  = 0;

endpackage

// File: rtl/reg_scoreboard.sv
// rtl/reg_scoreboard.sv - per-register busy bits, hazard detection and busy count
import regfile_scoreboard_pkg::*;

module reg_scoreboard #(
  parameter  int NREGS = NREGS_DEF,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          areset,
  input  logic [AW-1:0] rs1_addr,
  input  logic [AW-1:0] rs2_addr,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic          issue_valid,
  input  logic [AW-1:0] issue_rd,
  output logic          rs1_busy,
  output logic          rs2_busy,
  output logic          issue_stall,
  output logic [AW:0]   busy_cnt
);

  localparam logic [AW-1:0] ZERO = AW'(ZERO_REG);

  logic [NREGS-1:0] busy_q;
  logic [AW:0]      cnt_q;
  logic             rd_busy;
  logic             accept;
  logic             set_en;
  logic             clr_en;
  logic             set_inc;
  logic             clr_dec;

  // A writeback landing this cycle resolves the hazard, so it masks the busy bit
  always_comb begin
    rs1_busy    = (rs1_addr != ZERO) && busy_q[rs1_addr] && !(we && wa == rs1_addr);
    rs2_busy    = (rs2_addr != ZERO) && busy_q[rs2_addr] && !(we && wa == rs2_addr);
    rd_busy     = (issue_rd != ZERO) && busy_q[issue_rd] && !(we && wa == issue_rd);
    issue_stall = issue_valid && (rs1_busy || rs2_busy || rd_busy);
    accept      = issue_valid && !issue_stall;
    set_en      = accept && (issue_rd != ZERO);
    clr_en      = we && (wa != ZERO);
    // Count moves only on real bit transitions; set and clear of one register cancel out
    set_inc     = set_en && !busy_q[issue_rd];
    clr_dec     = clr_en && busy_q[wa] && !(set_en && issue_rd == wa);
  end

  // Busy bits and count; the set is applied after the clear so a same-register set wins
  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (clr_en) busy_q[wa] <= 1'b0;
      if (set_en) busy_q[issue_rd] <= 1'b1;
      cnt_q <= cnt_q + (AW+1)'(set_inc) - (AW+1)'(clr_dec);
    end
  end

  assign busy_cnt = cnt_q;

endmodule

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - register file with write-through bypass and issue scoreboard
import regfile_scoreboard_pkg::*;

module regfile_scoreboard #(
  parameter  int XLEN  = XLEN_DEF,
  parameter  int NREGS = NREGS_DEF,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            areset,
  input  logic [AW-1:0]   rs1_addr,
  input  logic [AW-1:0]   rs2_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  output logic            rs1_busy,
  output logic            rs2_busy,
  input  logic            we,
  input  logic [AW-1:0]   wa,
  input  logic [XLEN-1:0] wd,
  input  logic            issue_valid,
  input  logic [AW-1:0]   issue_rd,
  output logic            issue_stall,
  output logic [AW:0]     busy_cnt
);

  localparam logic [AW-1:0] ZERO = AW'(ZERO_REG);

  logic [XLEN-1:0] regs [NREGS];
  logic            wr_en;

  assign wr_en = we && (wa != ZERO);

  // Data array; entry 0 is never written so it stays at its reset value of 0
  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (wr_en) begin
      regs[wa] <= wd;
    end
  end

  // Combinational reads with write-through bypass of the current writeback
  always_comb begin
    rs1_data = regs[rs1_addr];
    rs2_data = regs[rs2_addr];
    if (wr_en && wa == rs1_addr) rs1_data = wd;
    if (wr_en && wa == rs2_addr) rs2_data = wd;
  end

  reg_scoreboard #(.NREGS(NREGS)) u_scoreboard (
    .clk         (clk),
    .areset      (areset),
    .rs1_addr    (rs1_addr),
    .rs2_addr    (rs2_addr),
    .we          (we),
    .wa          (wa),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .rs1_busy    (rs1_busy),
    .rs2_busy    (rs2_busy),
    .issue_stall (issue_stall),
    .busy_cnt    (busy_cnt)
  );

endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb/tb_regfile_scoreboard.sv - directed self-checking bench for regfile_scoreboard
module tb_regfile_scoreboard;

  logic        clk;
  logic        areset;
  logic [4:0]  rs1_addr, rs2_addr;
  logic [31:0] rs1_data, rs2_data;
  logic        rs1_busy, rs2_busy;
  logic        we;
  logic [4:0]  wa;
  logic [31:0] wd;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic        issue_stall;
  logic [5:0]  busy_cnt;

  int n_assert = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];

  regfile_scoreboard #(.XLEN(32), .NREGS(32)) dut (
    .clk(clk), .areset(areset),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .we(we), .wa(wa), .wd(wd),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .issue_stall(issue_stall), .busy_cnt(busy_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic expect_val(input logic [31:0] v);
    exp_q.push_back(v);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    n_assert++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $error("FAIL %s: observed %0h, no expected value queued", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) else begin
        n_fail++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, e);
      end
    end
  endtask

  task automatic idle();
    rs1_addr = 0; rs2_addr = 0; we = 0; wa = 0; wd = 0;
    issue_valid = 0; issue_rd = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    areset = 1'b0;
    #2;
    // during reset: nothing busy, reads zero, no stall
    rs1_addr = 5; issue_valid = 1; issue_rd = 5;
    expect_val(32'h0); expect_val(32'h0); expect_val(32'h0);
    #1;
    chk("reset_rs1_data", rs1_data);
    chk("reset_busy_cnt", 32'(busy_cnt));
    chk("reset_stall", 32'(issue_stall));
    idle();
    #3 areset = 1'b1;

    // write x5 with same-cycle bypass, then stored read
    tick();
    we = 1; wa = 5; wd = 32'hDEADBEEF; rs1_addr = 5;
    expect_val(32'hDEADBEEF);
    #1 chk("bypass_x5", rs1_data);
    tick();
    idle(); rs1_addr = 5; rs2_addr = 5;
    expect_val(32'hDEADBEEF); expect_val(32'hDEADBEEF);
    #1 chk("stored_x5_rs1", rs1_data); chk("stored_x5_rs2", rs2_data);

    // x0: write ignored, no bypass, issue to x0 does not mark busy
    tick();
    idle(); we = 1; wa = 0; wd = 32'h12345678; issue_valid = 1; issue_rd = 0;
    expect_val(32'h0); expect_val(32'h0);
    #1 chk("x0_no_bypass", rs1_data); chk("x0_issue_stall", 32'(issue_stall));
    tick();
    idle();
    expect_val(32'h0); expect_val(32'h0);
    #1 chk("x0_read", rs1_data); chk("x0_busy_cnt", 32'(busy_cnt));

    // issue rd=7, then RAW on rs2=7 stalls
    idle(); issue_valid = 1; issue_rd = 7;
    tick();
    idle(); issue_valid = 1; issue_rd = 0; rs2_addr = 7;
    expect_val(32'd1); expect_val(32'd1); expect_val(32'd1);
    #1 chk("raw_cnt", 32'(busy_cnt)); chk("raw_stall", 32'(issue_stall)); chk("raw_rs2_busy", 32'(rs2_busy));
    tick();
    // writeback of x7 in the same cycle resolves the hazard
    we = 1; wa = 7; wd = 32'hCAFE0007;
    expect_val(32'd0); expect_val(32'd0); expect_val(32'hCAFE0007);
    #1 chk("raw_wb_stall", 32'(issue_stall)); chk("raw_wb_rs2_busy", 32'(rs2_busy)); chk("raw_wb_rs2_data", rs2_data);
    tick();
    idle(); rs2_addr = 7;
    expect_val(32'd0); expect_val(32'hCAFE0007);
    #1 chk("raw_after_cnt", 32'(busy_cnt)); chk("raw_after_x7", rs2_data);

    // WAW: second issue to busy x9 stalls
    idle(); issue_valid = 1; issue_rd = 9;
    tick();
    expect_val(32'd1); expect_val(32'd1);
    #1 chk("waw_stall", 32'(issue_stall)); chk("waw_cnt", 32'(busy_cnt));
    tick();
    idle(); we = 1; wa = 9; wd = 32'h99;
    tick();
    idle();
    expect_val(32'd0);
    #1 chk("waw_clear_cnt", 32'(busy_cnt));

    // set and clear of x3 on the same edge: stays busy, takes data
    issue_valid = 1; issue_rd = 3;
    tick();
    idle(); issue_valid = 1; issue_rd = 3; we = 1; wa = 3; wd = 32'h33333333;
    expect_val(32'd0);
    #1 chk("same_edge_stall", 32'(issue_stall));
    tick();
    idle(); rs1_addr = 3;
    expect_val(32'd1); expect_val(32'd1); expect_val(32'h33333333);
    #1 chk("same_edge_cnt", 32'(busy_cnt)); chk("same_edge_busy", 32'(rs1_busy)); chk("same_edge_data", rs1_data);

    // clear x3, then writeback to non-busy x10 keeps count
    idle(); we = 1; wa = 3; wd = 32'h3;
    tick();
    idle(); we = 1; wa = 10; wd = 32'hA0A0A0A0;
    tick();
    idle(); rs1_addr = 10;
    expect_val(32'd0); expect_val(32'hA0A0A0A0);
    #1 chk("nonbusy_wb_cnt", 32'(busy_cnt)); chk("nonbusy_wb_data", rs1_data);

    // set x12 and clear x11 on the same edge: count unchanged
    idle(); issue_valid = 1; issue_rd = 11;
    tick();
    idle(); issue_valid = 1; issue_rd = 12; we = 1; wa = 11; wd = 32'hB;
    tick();
    idle(); rs1_addr = 12; rs2_addr = 11;
    expect_val(32'd1); expect_val(32'd1); expect_val(32'd0);
    #1 chk("swap_cnt", 32'(busy_cnt)); chk("swap_x12_busy", 32'(rs1_busy)); chk("swap_x11_busy", 32'(rs2_busy));
    idle(); we = 1; wa = 12; wd = 32'hC;
    tick();

    // three issues, then reset mid-sequence
    for (int i = 0; i < 3; i++) begin
      idle(); issue_valid = 1; issue_rd = (i == 2) ? 5'd4 : 5'(i + 1);
      tick();
    end
    idle(); rs1_addr = 5; rs2_addr = 1;
    expect_val(32'd3); expect_val(32'd1);
    #1 chk("three_cnt", 32'(busy_cnt)); chk("three_x1_busy", 32'(rs2_busy));
    #1 areset = 1'b0;
    expect_val(32'd0); expect_val(32'd0); expect_val(32'd0); expect_val(32'd0);
    #1 chk("mid_reset_cnt", 32'(busy_cnt)); chk("mid_reset_busy", 32'(rs2_busy));
    chk("mid_reset_x5", rs1_data); chk("mid_reset_x1", rs2_data);
    #2 areset = 1'b1;

    // first edge after release behaves as from power-up
    idle(); issue_valid = 1; issue_rd = 1;
    expect_val(32'd0);
    #1 chk("post_reset_stall", 32'(issue_stall));
    tick();
    idle();
    expect_val(32'd1);
    #1 chk("post_reset_cnt", 32'(busy_cnt));

    if (exp_q.size() != 0) begin
      n_assert++;
      n_fail++;
      $error("FAIL leftover_expectations: observed %0d expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
